// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring sequential divider.
// The state encoding is one-hot so that each state drives exactly one flop.
package div_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        SHIFT = 4'b0010,
        SUB   = 4'b0100,
        DONE  = 4'b1000
    } div_state_t;

    // Width of an iteration counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sequential_divider.sv
// Restoring shift-subtract unsigned divider: N-bit dividend / N-bit divisor.
// Each iteration takes one SHIFT cycle and one SUB cycle, and produces one quotient bit.
//
// Handshake: start is accepted only on a rising clock edge where ready=1, and the
// operands are sampled on that same edge. While the divider is busy (ready=0), start
// is ignored. done pulses high for exactly one cycle. quotient, remainder and
// div_by_zero then hold their values until the next accepted start.
module sequential_divider
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     dividend,
    input  logic [N-1:0]     divisor,
    output logic             ready,
    output logic             done,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output div_state_t       state_dbg
);

    localparam int CW = cnt_width(N);

    div_state_t      state, state_next;
    logic [N:0]      a;
    logic [N-1:0]    q;
    logic [N-1:0]    m;
    logic [CW-1:0]   count;
    logic            dbz;
    logic [N:0]      diff;

    assign diff = a - {1'b0, m};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (divisor == '0) ? DONE : SHIFT;
            SHIFT:   state_next = SUB;
            SUB:     state_next = (count == CW'(1)) ? DONE : SHIFT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a     <= '0;
            q     <= '0;
            m     <= '0;
            count <= '0;
            dbz   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a     <= '0;
                        q     <= dividend;
                        m     <= divisor;
                        count <= CW'(N);
                        dbz   <= (divisor == '0);
                    end
                end
                SHIFT: begin
                    {a, q} <= {a, q} << 1;
                end
                SUB: begin
                    // A negative trial difference leaves A untouched: that is the restore step.
                    if (!diff[N]) begin
                        a    <= diff;
                        q[0] <= 1'b1;
                    end
                    count <= count - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // On a zero divisor no iterations run, so q still holds the dividend.
    assign quotient    = dbz ? '1 : q;
    assign remainder   = dbz ? q : a[N-1:0];
    assign div_by_zero = dbz;
    assign ready       = (state == IDLE);
    assign done        = (state == DONE);
    assign state_dbg   = state;

endmodule
